// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
//   Shared definitions for the carry-lookahead accumulator slice.
//   - state_t      : accumulator control states (IDLE, ACCUM, HOLD)
//   - result_width : width of an adder result (operand width plus carry out)
// ---------------------------------------------------------------------------
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic int result_width(input int operand_width);
    return operand_width + 1;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// ---------------------------------------------------------------------------
// carry_lookahead_adder
//   Purely combinational WIDTH-bit adder with a carry-lookahead carry network
//   and no carry in.
// Ports:
//   i_add1   in  WIDTH    first operand
//   i_add2   in  WIDTH    second operand
//   o_result out WIDTH+1  sum, MSB is the carry out
// ---------------------------------------------------------------------------
module carry_lookahead_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]               i_add1,
  input  logic [WIDTH-1:0]               i_add2,
  output logic [result_width(WIDTH)-1:0] o_result
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;

  assign gen  = i_add1 & i_add2;
  assign prop = i_add1 ^ i_add2;

  // Every carry is written in flattened lookahead form:
  //   c[i+1] = OR over j<=i of ( g[j] AND p[j+1] AND ... AND p[i] )
  // so no carry depends on a previously computed carry.
  always_comb begin
    logic term;
    logic chain;
    carry    = '0;
    term     = 1'b0;
    chain    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      term = 1'b0;
      for (int j = 0; j <= i; j++) begin
        chain = 1'b1;
        for (int k = j + 1; k <= i; k++) begin
          chain = chain & prop[k];
        end
        term = term | (gen[j] & chain);
      end
      carry[i+1] = term;
    end
  end

  assign o_result = {carry[WIDTH], prop ^ carry[WIDTH-1:0]};

endmodule

// File: rtl/cla_accumulator.sv
// ---------------------------------------------------------------------------
// cla_accumulator
//   Streaming frame accumulator built around one carry_lookahead_adder that
//   sits in the acc -> adder -> acc feedback loop. Operands arrive over a
//   valid/ready handshake; the frame sum, a sticky overflow flag and a
//   saturating beat count leave over a second valid/ready handshake.
// Ports:
//   i_clk      in  1          clock, rising edge
//   i_rst_n    in  1          asynchronous active-low reset
//   i_valid    in  1          operand valid
//   o_ready    out 1          operand can be accepted (depends on state only)
//   i_data     in  WIDTH      operand, zero-extended into the accumulator
//   i_last     in  1          operand is the final beat of its frame
//   o_valid    out 1          frame result valid
//   i_ready    in  1          downstream takes the result
//   o_sum      out ACC_WIDTH  frame sum modulo 2^ACC_WIDTH
//   o_overflow out 1          a carry left ACC_WIDTH somewhere in the frame
//   o_beats    out BEAT_W     beats in the frame, saturating
// ---------------------------------------------------------------------------
module cla_accumulator
  import cla_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int ACC_WIDTH = 8,
  parameter int BEAT_W    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_last,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic                 o_overflow,
  output logic [BEAT_W-1:0]    o_beats
);

  localparam int RES_W = result_width(ACC_WIDTH);
  localparam logic [BEAT_W-1:0] BEATS_MAX = '1;

  state_t                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                  ovf_q, ovf_d;
  logic [BEAT_W-1:0]     beats_q, beats_d;
  logic [ACC_WIDTH-1:0]  sum_q, sum_d;
  logic                  ovf_out_q, ovf_out_d;
  logic [BEAT_W-1:0]     beats_out_q, beats_out_d;
  logic                  valid_q, valid_d;

  logic [ACC_WIDTH-1:0]  add_operand;
  logic [RES_W-1:0]      add_result;
  logic [BEAT_W-1:0]     beats_inc;
  logic                  ovf_next;

  assign add_operand = ACC_WIDTH'(i_data);

  carry_lookahead_adder #(
    .WIDTH (ACC_WIDTH)
  ) u_adder (
    .i_add1   (acc_q),
    .i_add2   (add_operand),
    .o_result (add_result)
  );

  assign beats_inc = (beats_q == BEATS_MAX) ? beats_q : beats_q + BEAT_W'(1);
  assign ovf_next  = ovf_q | add_result[ACC_WIDTH];

  // Ready comes from the state register only, so there is no combinational
  // path from i_valid to o_ready.
  assign o_ready = (state_q != HOLD);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    beats_d     = beats_q;
    sum_d       = sum_q;
    ovf_out_d   = ovf_out_q;
    beats_out_d = beats_out_q;
    valid_d     = valid_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (i_valid) begin
          acc_d   = add_result[ACC_WIDTH-1:0];
          ovf_d   = ovf_next;
          beats_d = beats_inc;
          if (i_last) begin
            sum_d       = add_result[ACC_WIDTH-1:0];
            ovf_out_d   = ovf_next;
            beats_out_d = beats_inc;
            valid_d     = 1'b1;
            state_d     = HOLD;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        // The running totals are cleared only when the result is taken; the
        // presented outputs keep their values until the next frame ends.
        if (i_ready) begin
          valid_d = 1'b0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          beats_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      beats_q     <= '0;
      sum_q       <= '0;
      ovf_out_q   <= 1'b0;
      beats_out_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      beats_q     <= beats_d;
      sum_q       <= sum_d;
      ovf_out_q   <= ovf_out_d;
      beats_out_q <= beats_out_d;
      valid_q     <= valid_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_sum      = sum_q;
  assign o_overflow = ovf_out_q;
  assign o_beats    = beats_out_q;

endmodule

// File: tb/tb_cla_accumulator.sv
// ---------------------------------------------------------------------------
// tb_cla_accumulator
//   Drives frames into cla_accumulator and compares each frame result with a
//   reference computed from the whole frame using plain integer arithmetic.
//   A second instance with BEAT_W=2 covers beat-count saturation.
// ---------------------------------------------------------------------------
module tb_cla_accumulator;

  localparam int WIDTH     = 3;
  localparam int ACC_WIDTH = 8;
  localparam int BEAT_W    = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_valid;
  logic                 o_ready;
  logic [WIDTH-1:0]     i_data;
  logic                 i_last;
  logic                 o_valid;
  logic                 i_ready;
  logic [ACC_WIDTH-1:0] o_sum;
  logic                 o_overflow;
  logic [BEAT_W-1:0]    o_beats;

  logic                 s_valid;
  logic                 s_oready;
  logic [WIDTH-1:0]     s_data;
  logic                 s_last;
  logic                 s_ovalid;
  logic                 s_iready;
  logic [ACC_WIDTH-1:0] s_sum;
  logic                 s_ovf;
  logic [1:0]           s_beats;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  beat_q[$];
  bit  ready_dropped;
  bit  early_valid;

  always #5 clk = ~clk;

  cla_accumulator #(
    .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .BEAT_W(BEAT_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready),
    .o_sum(o_sum), .o_overflow(o_overflow), .o_beats(o_beats)
  );

  cla_accumulator #(
    .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .BEAT_W(2)
  ) sat_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(s_valid), .o_ready(s_oready),
    .i_data(s_data), .i_last(s_last), .o_valid(s_ovalid), .i_ready(s_iready),
    .o_sum(s_sum), .o_overflow(s_ovf), .o_beats(s_beats)
  );

  // Reference model: the frame is summed as a plain integer. The total only
  // grows, so a carry leaves ACC_WIDTH at some beat exactly when the total
  // reaches 2^ACC_WIDTH.
  function automatic int frame_total();
    int t = 0;
    foreach (beat_q[i]) t += beat_q[i];
    return t;
  endfunction

  function automatic int exp_sum();
    return frame_total() % (1 << ACC_WIDTH);
  endfunction

  function automatic bit exp_ovf();
    return frame_total() >= (1 << ACC_WIDTH);
  endfunction

  function automatic int exp_beats(input int bw);
    int lim = (1 << bw) - 1;
    return (beat_q.size() > lim) ? lim : beat_q.size();
  endfunction

  // Sends beat_q as one frame with up to gap_max idle cycles before each
  // beat; idle cycles carry junk data and i_last to show they are ignored.
  // Returns at the negedge following acceptance of the last beat.
  task automatic drive_frame(input int gap_max);
    int gaps;
    ready_dropped = 1'b0;
    early_valid   = 1'b0;
    for (int i = 0; i < beat_q.size(); i++) begin
      gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int g = 0; g < gaps; g++) begin
        @(negedge clk);
        if (o_valid) early_valid = 1'b1;
        i_valid = 1'b0;
        i_last  = 1'($urandom_range(1, 0));
        i_data  = WIDTH'($urandom);
      end
      @(negedge clk);
      if (!o_ready) ready_dropped = 1'b1;
      if (o_valid) early_valid = 1'b1;
      i_valid = 1'b1;
      i_data  = WIDTH'(beat_q[i]);
      i_last  = (i == beat_q.size() - 1);
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    i_valid = 1'b0; i_data = '0; i_last = 1'b0; i_ready = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_iready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({o_valid, o_sum, o_overflow, o_beats, o_ready} !== {1'b0, 8'd0, 1'b0, 8'd0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL reset_values got valid=%0b sum=%0d ovf=%0b beats=%0d ready=%0b expected 0 0 0 0 1",
               o_valid, o_sum, o_overflow, o_beats, o_ready);
    end
  endtask

  task automatic test_basic_frame();
    beat_q = '{1, 2, 3};
    i_ready = 1'b1;
    drive_frame(0);
    n_checks++;
    if (early_valid || o_valid !== 1'b1 || o_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_latency got early=%0b valid=%0b ready=%0b expected 0 1 0",
               early_valid, o_valid, o_ready);
    end
    n_checks++;
    if ({o_sum, o_overflow, o_beats} !== {8'd6, 1'b0, 8'd3}) begin
      n_fail++;
      $display("[TB] FAIL basic_result got sum=%0d ovf=%0b beats=%0d expected 6 0 3",
               o_sum, o_overflow, o_beats);
    end
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_sum !== 8'd6) begin
      n_fail++;
      $display("[TB] FAIL basic_release got valid=%0b ready=%0b sum=%0d expected 0 1 6",
               o_valid, o_ready, o_sum);
    end
  endtask

  task automatic test_single_beat();
    beat_q = '{7};
    drive_frame(0);
    n_checks++;
    if ({o_valid, o_sum, o_beats} !== {1'b1, 8'd7, 8'd1}) begin
      n_fail++;
      $display("[TB] FAIL single_beat got valid=%0b sum=%0d beats=%0d expected 1 7 1",
               o_valid, o_sum, o_beats);
    end
    @(negedge clk);
    beat_q = '{5};
    drive_frame(1);
    n_checks++;
    if ({o_valid, o_sum, o_beats} !== {1'b1, 8'd5, 8'd1}) begin
      n_fail++;
      $display("[TB] FAIL single_restart got valid=%0b sum=%0d beats=%0d expected 1 5 1",
               o_valid, o_sum, o_beats);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    beat_q.delete();
    repeat (37) beat_q.push_back(7);
    drive_frame(0);
    n_checks++;
    if ({o_valid, o_sum, o_overflow, o_beats} !== {1'b1, 8'd3, 1'b1, 8'd37}) begin
      n_fail++;
      $display("[TB] FAIL overflow got valid=%0b sum=%0d ovf=%0b beats=%0d expected 1 3 1 37",
               o_valid, o_sum, o_overflow, o_beats);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit bad = 1'b0;
    i_ready = 1'b0;
    beat_q = '{4, 5};
    drive_frame(0);
    for (int c = 0; c < 5; c++) begin
      i_valid = 1'b1;
      i_data  = WIDTH'($urandom);
      i_last  = 1'($urandom_range(1, 0));
      @(negedge clk);
      if ({o_valid, o_ready, o_sum, o_overflow, o_beats} !== {1'b1, 1'b0, 8'd9, 1'b0, 8'd2})
        bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("[TB] FAIL backpressure_hold got valid=%0b ready=%0b sum=%0d beats=%0d expected 1 0 9 2",
               o_valid, o_ready, o_sum, o_beats);
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL backpressure_release got valid=%0b ready=%0b expected 0 1", o_valid, o_ready);
    end
    beat_q = '{1};
    drive_frame(0);
    n_checks++;
    if ({o_valid, o_sum, o_beats} !== {1'b1, 8'd1, 8'd1}) begin
      n_fail++;
      $display("[TB] FAIL backpressure_next got valid=%0b sum=%0d beats=%0d expected 1 1 1",
               o_valid, o_sum, o_beats);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    i_valid = 1'b1; i_data = 3'd6; i_last = 1'b0;
    @(negedge clk);
    i_data = 3'd6;
    @(negedge clk);
    i_valid = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({o_valid, o_ready, o_sum, o_overflow, o_beats} !== {1'b0, 1'b1, 8'd0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_frame got valid=%0b ready=%0b sum=%0d ovf=%0b beats=%0d expected 0 1 0 0 0",
               o_valid, o_ready, o_sum, o_overflow, o_beats);
    end
    rst_n = 1'b1;
    beat_q = '{2};
    drive_frame(0);
    n_checks++;
    if ({o_valid, o_sum, o_overflow, o_beats} !== {1'b1, 8'd2, 1'b0, 8'd1}) begin
      n_fail++;
      $display("[TB] FAIL reset_next_frame got valid=%0b sum=%0d ovf=%0b beats=%0d expected 1 2 0 1",
               o_valid, o_sum, o_overflow, o_beats);
    end
    @(negedge clk);
  endtask

  task automatic test_beat_saturation();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = '0;
      s_last  = (i == 4);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    n_checks++;
    if ({s_ovalid, s_sum, s_ovf, s_beats} !== {1'b1, 8'd0, 1'b0, 2'd3}) begin
      n_fail++;
      $display("[TB] FAIL beat_saturation got valid=%0b sum=%0d ovf=%0b beats=%0d expected 1 0 0 3",
               s_ovalid, s_sum, s_ovf, s_beats);
    end
    @(negedge clk);
  endtask

  task automatic test_random_frames();
    int exp_s;
    int exp_b;
    bit exp_o;
    int hold;
    for (int f = 0; f < 24; f++) begin
      beat_q.delete();
      repeat ($urandom_range(45, 1)) beat_q.push_back(int'($urandom_range(7, 0)));
      exp_s = exp_sum();
      exp_o = exp_ovf();
      exp_b = exp_beats(BEAT_W);
      i_ready = 1'b0;
      drive_frame(2);
      n_checks++;
      if (ready_dropped || early_valid || o_valid !== 1'b1 || o_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL random_handshake frame %0d got dropped=%0b early=%0b valid=%0b ready=%0b expected 0 0 1 0",
                 f, ready_dropped, early_valid, o_valid, o_ready);
      end
      n_checks++;
      if (o_sum !== exp_s[ACC_WIDTH-1:0] || o_overflow !== exp_o || o_beats !== exp_b[BEAT_W-1:0]) begin
        n_fail++;
        $display("[TB] FAIL random_result frame %0d got sum=%0d ovf=%0b beats=%0d expected %0d %0b %0d",
                 f, o_sum, o_overflow, o_beats, exp_s, exp_o, exp_b);
      end
      hold = int'($urandom_range(3, 0));
      for (int c = 0; c < hold; c++) begin
        i_valid = 1'($urandom_range(1, 0));
        i_data  = WIDTH'($urandom);
        i_last  = 1'($urandom_range(1, 0));
        @(negedge clk);
      end
      n_checks++;
      if (o_valid !== 1'b1 || o_sum !== exp_s[ACC_WIDTH-1:0] || o_beats !== exp_b[BEAT_W-1:0]) begin
        n_fail++;
        $display("[TB] FAIL random_stable frame %0d got valid=%0b sum=%0d beats=%0d expected 1 %0d %0d",
                 f, o_valid, o_sum, o_beats, exp_s, exp_b);
      end
      i_valid = 1'b0;
      i_last  = 1'b0;
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      n_checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL random_release frame %0d got valid=%0b ready=%0b expected 0 1",
                 f, o_valid, o_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_single_beat();
    test_overflow();
    test_backpressure();
    test_reset_mid_frame();
    test_beat_saturation();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
